// File: rtl/cell_nbr_counter_pkg.sv
// Shared types and constants for the Game of Life neighbour-count engine.
package cell_nbr_counter_pkg;

    localparam int NEIGHBOURS_CNT = 8;
    localparam int NBR_CNT_W      = 4;

    localparam logic [8:0] B3_MASK  = 9'b000001000;
    localparam logic [8:0] S23_MASK = 9'b000001100;

    // Issue index 0..7 selects a neighbour, 8 is the cell's own read.
    localparam logic [3:0] SELF_IDX = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESULT
    } nbr_cnt_state_t;

    typedef struct packed {
        logic vld;
        logic self_rd;
    } rd_track_t;

    function automatic logic apply_rule(
        input logic                 cur,
        input logic [NBR_CNT_W-1:0] cnt,
        input logic [8:0]           birth,
        input logic [8:0]           surv
    );
        return cur ? surv[cnt] : birth[cnt];
    endfunction

endpackage

// File: rtl/cell_nbr_counter_if.sv
// Request, field-memory read and result channels of the neighbour-count engine.
interface cell_nbr_counter_if
    import cell_nbr_counter_pkg::*;
#(
    parameter int X_ADR_SIZE = 2,
    parameter int Y_ADR_SIZE = 2
);

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [X_ADR_SIZE-1:0] i_cell_x_adr;
    logic [Y_ADR_SIZE-1:0] i_cell_y_adr;

    logic                  o_rd_en;
    logic [X_ADR_SIZE-1:0] o_rd_x_adr;
    logic [Y_ADR_SIZE-1:0] o_rd_y_adr;
    logic                  i_rd_data;

    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [X_ADR_SIZE-1:0] o_res_x_adr;
    logic [Y_ADR_SIZE-1:0] o_res_y_adr;
    logic [NBR_CNT_W-1:0]  o_nbr_cnt;
    logic                  o_cur_state;
    logic                  o_next_state;

    // Engine side.
    modport slave (
        input  i_req_valid, i_cell_x_adr, i_cell_y_adr, i_rd_data, i_res_ready,
        output o_req_ready, o_rd_en, o_rd_x_adr, o_rd_y_adr,
        output o_res_valid, o_res_x_adr, o_res_y_adr, o_nbr_cnt, o_cur_state, o_next_state
    );

    // Scan controller / field RAM side.
    modport master (
        output i_req_valid, i_cell_x_adr, i_cell_y_adr, i_rd_data, i_res_ready,
        input  o_req_ready, o_rd_en, o_rd_x_adr, o_rd_y_adr,
        input  o_res_valid, o_res_x_adr, o_res_y_adr, o_nbr_cnt, o_cur_state, o_next_state
    );

endinterface

// File: rtl/cell_nbr_counter_nbr_addr_gen.sv
// Combinational neighbour address generator: 8 x/y addresses in row-major order
// around the cell (0 1 2 / 3 x 4 / 5 6 7) plus per-neighbour relevance flags.
module nbr_addr_gen
    import cell_nbr_counter_pkg::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 3,
    parameter int WRAP       = 0,
    parameter int X_ADR_SIZE = $clog2(FIELD_W),
    parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic [X_ADR_SIZE-1:0]                     cell_x,
    input  logic [Y_ADR_SIZE-1:0]                     cell_y,
    output logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbr_x,
    output logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbr_y,
    output logic [NEIGHBOURS_CNT-1:0]                 nbr_rel
);

    localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);
    localparam logic                  WRAP_EN = (WRAP != 0);

    logic [X_ADR_SIZE-1:0] x_lo, x_hi;
    logic [Y_ADR_SIZE-1:0] y_lo, y_hi;
    logic                  has_l, has_r, has_u, has_d;

    // Explicit compares so non-power-of-two fields wrap at FIELD_W/FIELD_H.
    always_comb begin
        x_lo  = (cell_x == '0)    ? X_MAX : cell_x - X_ADR_SIZE'(1);
        x_hi  = (cell_x == X_MAX) ? '0    : cell_x + X_ADR_SIZE'(1);
        y_lo  = (cell_y == '0)    ? Y_MAX : cell_y - Y_ADR_SIZE'(1);
        y_hi  = (cell_y == Y_MAX) ? '0    : cell_y + Y_ADR_SIZE'(1);

        has_l = WRAP_EN || (cell_x != '0);
        has_r = WRAP_EN || (cell_x != X_MAX);
        has_u = WRAP_EN || (cell_y != '0);
        has_d = WRAP_EN || (cell_y != Y_MAX);

        nbr_x   = {x_hi, cell_x, x_lo, x_hi, x_lo, x_hi, cell_x, x_lo};
        nbr_y   = {y_hi, y_hi, y_hi, cell_y, cell_y, y_lo, y_lo, y_lo};
        nbr_rel = {has_r & has_d, has_d, has_l & has_d, has_r, has_l,
                   has_r & has_u, has_u, has_l & has_u};
    end

endmodule

// File: rtl/cell_nbr_counter.sv
// Sequential neighbour-count engine: issues the relevant neighbour reads plus a
// self read, counts live neighbours and applies the birth/survival rule.
module cell_nbr_counter
    import cell_nbr_counter_pkg::*;
#(
    parameter int         FIELD_W    = 4,
    parameter int         FIELD_H    = 3,
    parameter int         WRAP       = 0,
    parameter int         RD_LAT     = 1,
    parameter logic [8:0] BIRTH_MASK = B3_MASK,
    parameter logic [8:0] SURV_MASK  = S23_MASK,
    parameter int         X_ADR_SIZE = $clog2(FIELD_W),
    parameter int         Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input logic               i_clk,
    input logic               i_rst_n,
    cell_nbr_counter_if.slave bus
);

    localparam int MIN_DIM = (WRAP != 0) ? 3 : 2;

    if (FIELD_W < MIN_DIM || FIELD_H < MIN_DIM || RD_LAT < 1) begin : g_bad_params
        $error("cell_nbr_counter: FIELD_W/FIELD_H too small for WRAP, or RD_LAT < 1");
    end

    nbr_cnt_state_t state;

    logic [3:0]            idx;
    logic [3:0]            pick;
    logic                  issue;
    logic                  pick_self;

    logic [X_ADR_SIZE-1:0] cell_x;
    logic [Y_ADR_SIZE-1:0] cell_y;
    logic [NBR_CNT_W-1:0]  cnt;
    logic                  cur_state;
    logic                  next_state;
    logic                  res_valid;

    logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbr_x;
    logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbr_y;
    logic [NEIGHBOURS_CNT-1:0]                 nbr_rel;

    rd_track_t trk [RD_LAT];
    rd_track_t trk_out;

    nbr_addr_gen #(
        .FIELD_W   (FIELD_W),
        .FIELD_H   (FIELD_H),
        .WRAP      (WRAP),
        .X_ADR_SIZE(X_ADR_SIZE),
        .Y_ADR_SIZE(Y_ADR_SIZE)
    ) u_addr_gen (
        .cell_x (cell_x),
        .cell_y (cell_y),
        .nbr_x  (nbr_x),
        .nbr_y  (nbr_y),
        .nbr_rel(nbr_rel)
    );

    // Lowest relevant neighbour at or above idx; falls through to the self read,
    // so skipped neighbours cost no cycle.
    always_comb begin
        pick = SELF_IDX;
        for (int unsigned k = NEIGHBOURS_CNT; k > 0; k--) begin
            if ((k - 1) >= 32'(idx) && nbr_rel[k-1]) begin
                pick = 4'(k - 1);
            end
        end
    end

    assign issue     = (state == ISSUE);
    assign pick_self = (pick == SELF_IDX);
    assign trk_out   = trk[RD_LAT-1];

    assign bus.o_req_ready  = (state == IDLE);
    assign bus.o_rd_en      = issue;
    assign bus.o_rd_x_adr   = !issue ? '0 : (pick_self ? cell_x : nbr_x[pick[2:0]]);
    assign bus.o_rd_y_adr   = !issue ? '0 : (pick_self ? cell_y : nbr_y[pick[2:0]]);
    assign bus.o_res_valid  = res_valid;
    assign bus.o_res_x_adr  = cell_x;
    assign bus.o_res_y_adr  = cell_y;
    assign bus.o_nbr_cnt    = cnt;
    assign bus.o_cur_state  = cur_state;
    assign bus.o_next_state = next_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cell_x     <= '0;
            cell_y     <= '0;
            cnt        <= '0;
            cur_state  <= 1'b0;
            next_state <= 1'b0;
            res_valid  <= 1'b0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                trk[k] <= '0;
            end
        end else begin
            trk[0] <= '{vld: issue, self_rd: issue && pick_self};
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                trk[k] <= trk[k-1];
            end

            // Self is always the last read, so the count is final when it returns.
            if (trk_out.vld) begin
                if (trk_out.self_rd) begin
                    cur_state  <= bus.i_rd_data;
                    next_state <= apply_rule(bus.i_rd_data, cnt, BIRTH_MASK, SURV_MASK);
                end else begin
                    cnt <= cnt + NBR_CNT_W'(bus.i_rd_data);
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        cell_x <= bus.i_cell_x_adr;
                        cell_y <= bus.i_cell_y_adr;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    idx <= pick + 4'd1;
                    if (pick_self) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (trk_out.vld && trk_out.self_rd) begin
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (bus.i_res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_nbr_counter.sv
// Bench for cell_nbr_counter: four instances covering WRAP {0,1} x RD_LAT {1,3}
// on a 4x3 field, each with its own latency-accurate field memory.
module tb_cell_nbr_counter;

    localparam int FW = 4;
    localparam int FH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      rst_n_a, req_valid_a, res_ready_a;
    logic [3:0][1:0] cell_x_a, cell_y_a;
    logic [3:0]      req_ready_a, rd_en_a, res_valid_a, cur_a, next_a;
    logic [3:0][1:0] rd_x_a, rd_y_a, res_x_a, res_y_a;
    logic [3:0][3:0] cnt_a;
    logic [15:0]     field;

    int total = 0;
    int bad   = 0;

    int   obs_rx[$], obs_ry[$], exp_rx[$], exp_ry[$];
    int   obs_lat, exp_lat, exp_cnt;
    logic exp_cur, exp_next;

    // Instance g: WRAP = g/2, RD_LAT = 1 for even g, 3 for odd g.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = g / 2;
        localparam int L = (g % 2 == 1) ? 3 : 1;

        cell_nbr_counter_if #(.X_ADR_SIZE(2), .Y_ADR_SIZE(2)) bus ();

        assign bus.i_req_valid  = req_valid_a[g];
        assign bus.i_cell_x_adr = cell_x_a[g];
        assign bus.i_cell_y_adr = cell_y_a[g];
        assign bus.i_res_ready  = res_ready_a[g];
        assign req_ready_a[g]   = bus.o_req_ready;
        assign rd_en_a[g]       = bus.o_rd_en;
        assign rd_x_a[g]        = bus.o_rd_x_adr;
        assign rd_y_a[g]        = bus.o_rd_y_adr;
        assign res_valid_a[g]   = bus.o_res_valid;
        assign res_x_a[g]       = bus.o_res_x_adr;
        assign res_y_a[g]       = bus.o_res_y_adr;
        assign cnt_a[g]         = bus.o_nbr_cnt;
        assign cur_a[g]         = bus.o_cur_state;
        assign next_a[g]        = bus.o_next_state;

        cell_nbr_counter #(
            .FIELD_W(FW),
            .FIELD_H(FH),
            .WRAP   (W),
            .RD_LAT (L)
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n_a[g]),
            .bus    (bus)
        );

        // Field RAM: data for a read appears L cycles later; idle slots carry noise.
        logic [L-1:0] pipe;
        always @(posedge clk) begin
            if (bus.o_rd_en)
                pipe <= L'({pipe, field[4'(32'(bus.o_rd_y_adr) * FW + 32'(bus.o_rd_x_adr))]});
            else
                pipe <= L'({pipe, 1'($urandom_range(1, 0))});
        end
        assign bus.i_rd_data = pipe[L-1];
    end

    function automatic logic cell_at(input int x, input int y);
        return field[4'(y * FW + x)];
    endfunction

    function automatic int lat_of(input int d);
        return (d % 2 == 1) ? 3 : 1;
    endfunction

    // Reference: walk the 3x3 window row by row, skip or wrap off-field cells, self last.
    task automatic model(input int d, input int x, input int y);
        int nx, ny;
        exp_rx.delete();
        exp_ry.delete();
        exp_cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (dx == 0 && dy == 0) continue;
                if (d / 2 == 1) begin
                    nx = (nx + FW) % FW;
                    ny = (ny + FH) % FH;
                end else if (nx < 0 || nx >= FW || ny < 0 || ny >= FH) begin
                    continue;
                end
                exp_rx.push_back(nx);
                exp_ry.push_back(ny);
                exp_cnt += int'(cell_at(nx, ny));
            end
        end
        exp_rx.push_back(x);
        exp_ry.push_back(y);
        exp_cur  = cell_at(x, y);
        exp_next = exp_cur ? (exp_cnt == 2 || exp_cnt == 3) : (exp_cnt == 3);
        exp_lat  = exp_rx.size() + lat_of(d) + 1;
    endtask

    // Stimulus only: issue a request and record reads and result latency.
    task automatic do_req(input int d, input int x, input int y);
        obs_rx.delete();
        obs_ry.delete();
        obs_lat = -1;
        for (int k = 0; k < 20 && !req_ready_a[d]; k++) begin
            @(posedge clk); #1;
        end
        req_valid_a[d] = 1'b1;
        cell_x_a[d]    = 2'(x);
        cell_y_a[d]    = 2'(y);
        @(posedge clk); #1;
        req_valid_a[d] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (res_valid_a[d]) begin
                obs_lat = k;
                break;
            end
            if (rd_en_a[d]) begin
                obs_rx.push_back(int'(rd_x_a[d]));
                obs_ry.push_back(int'(rd_y_a[d]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume(input int d);
        res_ready_a[d] = 1'b1;
        @(posedge clk); #1;
        res_ready_a[d] = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst_n_a = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            got = {req_ready_a[d], rd_en_a[d], res_valid_a[d], cnt_a[d], cur_a[d], next_a[d],
                   res_x_a[d], res_y_a[d], rd_x_a[d], rd_y_a[d]};
            total++;
            if (got !== 17'h10000) begin
                bad++;
                $display("FAIL reset_state[%0d]: got %b want %b", d, got, 17'h10000);
            end
        end
        rst_n_a = '1;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if ({req_ready_a[d], rd_en_a[d], res_valid_a[d]} !== 3'b100) begin
                bad++;
                $display("FAIL post_reset_idle[%0d]: got %b want 100", d,
                         {req_ready_a[d], rd_en_a[d], res_valid_a[d]});
            end
        end
    endtask

    task automatic test_corner();
        field = 16'h0fff;
        model(0, 0, 0);
        do_req(0, 0, 0);
        total++;
        if (obs_rx.size() != exp_rx.size()) begin
            bad++;
            $display("FAIL corner_nreads: got %0d want %0d", obs_rx.size(), exp_rx.size());
        end
        for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++) begin
            total++;
            if (obs_rx[i] != exp_rx[i] || obs_ry[i] != exp_ry[i]) begin
                bad++;
                $display("FAIL corner_read[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                         obs_rx[i], obs_ry[i], exp_rx[i], exp_ry[i]);
            end
        end
        total++;
        if (obs_lat != exp_lat) begin
            bad++;
            $display("FAIL corner_latency: got %0d want %0d", obs_lat, exp_lat);
        end
        total++;
        if ({cnt_a[0], cur_a[0], next_a[0]} !== {4'(exp_cnt), exp_cur, exp_next}) begin
            bad++;
            $display("FAIL corner_result: got cnt=%0d cur=%b next=%b want cnt=%0d cur=%b next=%b",
                     cnt_a[0], cur_a[0], next_a[0], exp_cnt, exp_cur, exp_next);
        end
        consume(0);
    endtask

    task automatic test_edge();
        int xs[2] = '{1, 1};
        int ys[2] = '{0, 1};
        field = 16'h0070;  // (0,1) (1,1) (2,1) live
        for (int t = 0; t < 2; t++) begin
            model(0, xs[t], ys[t]);
            do_req(0, xs[t], ys[t]);
            total++;
            if (obs_rx.size() != exp_rx.size() || obs_lat != exp_lat) begin
                bad++;
                $display("FAIL edge_timing(%0d,%0d): got reads=%0d lat=%0d want reads=%0d lat=%0d",
                         xs[t], ys[t], obs_rx.size(), obs_lat, exp_rx.size(), exp_lat);
            end
            total++;
            if ({cnt_a[0], cur_a[0], next_a[0], res_x_a[0], res_y_a[0]} !==
                {4'(exp_cnt), exp_cur, exp_next, 2'(xs[t]), 2'(ys[t])}) begin
                bad++;
                $display("FAIL edge_result(%0d,%0d): got cnt=%0d cur=%b next=%b want cnt=%0d cur=%b next=%b",
                         xs[t], ys[t], cnt_a[0], cur_a[0], next_a[0], exp_cnt, exp_cur, exp_next);
            end
            consume(0);
        end
    endtask

    task automatic test_wrap();
        field = 16'h0800;  // only (3,2) live
        model(2, 0, 0);
        do_req(2, 0, 0);
        total++;
        if (obs_rx.size() != exp_rx.size()) begin
            bad++;
            $display("FAIL wrap_nreads: got %0d want %0d", obs_rx.size(), exp_rx.size());
        end
        for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++) begin
            total++;
            if (obs_rx[i] != exp_rx[i] || obs_ry[i] != exp_ry[i]) begin
                bad++;
                $display("FAIL wrap_read[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                         obs_rx[i], obs_ry[i], exp_rx[i], exp_ry[i]);
            end
        end
        total++;
        if ({cnt_a[2], cur_a[2], next_a[2]} !== {4'(exp_cnt), exp_cur, exp_next} || obs_lat != exp_lat) begin
            bad++;
            $display("FAIL wrap_result: got cnt=%0d cur=%b next=%b lat=%0d want cnt=%0d cur=%b next=%b lat=%0d",
                     cnt_a[2], cur_a[2], next_a[2], obs_lat, exp_cnt, exp_cur, exp_next, exp_lat);
        end
        consume(2);
    endtask

    task automatic test_hold();
        logic [12:0] got, want;
        field = 16'($urandom) & 16'h0fff;
        model(0, 2, 1);
        do_req(0, 2, 1);
        total++;
        if (obs_lat != exp_lat) begin
            bad++;
            $display("FAIL hold_latency: got %0d want %0d", obs_lat, exp_lat);
        end
        want = {1'b1, 4'(exp_cnt), exp_cur, exp_next, 2'd2, 2'd1, 1'b0, 1'b0};
        for (int c = 0; c < 10; c++) begin
            got = {res_valid_a[0], cnt_a[0], cur_a[0], next_a[0], res_x_a[0], res_y_a[0],
                   req_ready_a[0], rd_en_a[0]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hold_stable[%0d]: got %b want %b", c, got, want);
            end
            @(posedge clk); #1;
        end
        consume(0);
        total++;
        if ({req_ready_a[0], res_valid_a[0]} !== 2'b10) begin
            bad++;
            $display("FAIL hold_release: got ready/valid=%b want 10", {req_ready_a[0], res_valid_a[0]});
        end
    endtask

    task automatic test_reset_midflight();
        int nrd = 0;
        field = 16'h0fff;
        req_valid_a[1] = 1'b1;
        cell_x_a[1]    = 2'd1;
        cell_y_a[1]    = 2'd1;
        @(posedge clk); #1;
        req_valid_a[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rd_en_a[1]) nrd++;
            if (nrd == 3) break;
            @(posedge clk); #1;
        end
        total++;
        if (nrd != 3) begin
            bad++;
            $display("FAIL midflight_reads: got %0d want 3", nrd);
        end
        rst_n_a[1] = 1'b0;
        @(posedge clk); #1;
        rst_n_a[1] = 1'b1;
        total++;
        if ({rd_en_a[1], res_valid_a[1], req_ready_a[1]} !== 3'b001) begin
            bad++;
            $display("FAIL midflight_reset: got rd/valid/ready=%b want 001",
                     {rd_en_a[1], res_valid_a[1], req_ready_a[1]});
        end
        model(1, 2, 1);
        do_req(1, 2, 1);
        total++;
        if ({cnt_a[1], cur_a[1], next_a[1]} !== {4'(exp_cnt), exp_cur, exp_next} || obs_lat != exp_lat) begin
            bad++;
            $display("FAIL midflight_result: got cnt=%0d cur=%b next=%b lat=%0d want cnt=%0d cur=%b next=%b lat=%0d",
                     cnt_a[1], cur_a[1], next_a[1], obs_lat, exp_cnt, exp_cur, exp_next, exp_lat);
        end
        consume(1);
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 4; d++) begin
            for (int rep = 0; rep < 2; rep++) begin
                field = 16'($urandom) & 16'h0fff;
                for (int y = 0; y < FH; y++) begin
                    for (int x = 0; x < FW; x++) begin
                        model(d, x, y);
                        do_req(d, x, y);
                        total++;
                        if (obs_lat != exp_lat || obs_rx.size() != exp_rx.size()) begin
                            bad++;
                            $display("FAIL sweep_timing[d%0d](%0d,%0d): got lat=%0d reads=%0d want lat=%0d reads=%0d",
                                     d, x, y, obs_lat, obs_rx.size(), exp_lat, exp_rx.size());
                        end
                        total++;
                        if ({cnt_a[d], cur_a[d], next_a[d], res_x_a[d], res_y_a[d]} !==
                            {4'(exp_cnt), exp_cur, exp_next, 2'(x), 2'(y)}) begin
                            bad++;
                            $display("FAIL sweep_result[d%0d](%0d,%0d): got cnt=%0d cur=%b next=%b adr=(%0d,%0d) want cnt=%0d cur=%b next=%b",
                                     d, x, y, cnt_a[d], cur_a[d], next_a[d], res_x_a[d], res_y_a[d],
                                     exp_cnt, exp_cur, exp_next);
                        end
                        consume(d);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n_a     = '0;
        req_valid_a = '0;
        res_ready_a = '0;
        cell_x_a    = '0;
        cell_y_a    = '0;
        field       = '0;
        test_reset();
        test_corner();
        test_edge();
        test_wrap();
        test_hold();
        test_reset_midflight();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cell_nbr_counter.md
Name: cell_nbr_counter

Overview:
Sequential neighbour-count engine for the Game of Life field. It accepts one cell address per request and issues the cell's relevant neighbour reads plus a self read to a single-port field memory with latency RD_LAT. It accumulates the live count, applies a parametrised birth/survival rule, and returns count, current state and next state over a valid/ready handshake. It generalises neighbour addressing with an optional toroidal (wrap) mode and sits between the generation scan controller and the field RAM.

Parameters:
FIELD_W, 4, field width in cells; must be >=2, or >=3 when WRAP=1 (elaboration-time assertion).
FIELD_H, 3, field height in cells; must be >=2, or >=3 when WRAP=1.
WRAP, 0, 0 = edges are dead (out-of-field neighbours skipped); 1 = toroidal wrap.
RD_LAT, 1, memory read latency in cycles (>=1).
BIRTH_MASK, 9'b000001000, bit k set: a dead cell with k live neighbours becomes live (B3).
SURV_MASK, 9'b000001100, bit k set: a live cell with k live neighbours stays live (S23).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_req_valid  in  1  request valid
o_req_ready  out  1  engine idle, can accept a request
i_cell_x_adr  in  X_ADR_SIZE=$clog2(FIELD_W)  requested cell x
i_cell_y_adr  in  Y_ADR_SIZE=$clog2(FIELD_H)  requested cell y
o_rd_en  out  1  memory read strobe
o_rd_x_adr  out  X_ADR_SIZE  read x address
o_rd_y_adr  out  Y_ADR_SIZE  read y address
i_rd_data  in  1  cell state, valid RD_LAT cycles after o_rd_en
o_res_valid  out  1  result valid
i_res_ready  in  1  result consumed
o_res_x_adr / o_res_y_adr  out  X/Y_ADR_SIZE  address of the evaluated cell
o_nbr_cnt  out  4  live neighbour count, 0..8
o_cur_state  out  1  current state of the cell
o_next_state  out  1  next-generation state

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values: o_req_ready=1; o_rd_en, o_res_valid, o_nbr_cnt, o_cur_state and o_next_state are 0; addresses are 0.
- FSM states:
  - IDLE: o_req_ready=1. On i_req_valid, latch the address and go to ISSUE.
  - ISSUE: one read per cycle, in order nbr 0..7 (0 1 2 / 3 x 4 / 5 6 7), then self.
  - DRAIN: wait until all RD_LAT responses have returned.
  - RESULT: o_res_valid=1. On i_res_ready, go to IDLE.
- WRAP=0: irrelevant neighbours (x-1 at x=0, x+1 at x=FIELD_W-1, same for y) are skipped, with no cycle spent on them. The number of reads is n = 4 (corner), 6 (edge) or 9 (interior).
- WRAP=1: all 9 reads are issued. x-1 at 0 maps to FIELD_W-1 and x+1 at FIELD_W-1 maps to 0, using explicit compare, not power-of-two truncation. The same rule applies to y.
- Response tracking uses an RD_LAT-deep shift register of {valid, is_self}.
  - Neighbour responses increment the count.
  - The self response sets o_cur_state.
- Timing: handshake in cycle T; reads in cycles T+1..T+n; last data in cycle T+n+RD_LAT; o_res_valid from cycle T+n+RD_LAT+1.
- Next state = o_cur_state ? SURV_MASK[o_nbr_cnt] : BIRTH_MASK[o_nbr_cnt].
- All result outputs are registered and held stable while o_res_valid=1 and i_res_ready=0.
- No read is issued outside ISSUE, and o_req_ready=0 outside IDLE.
- A new request is accepted no earlier than the cycle after the result handshake.
- The counter is 4 bits and cannot overflow, since at most 8 neighbours are counted.
- Reset in any state:
  - Outputs return to reset values on the next edge.
  - The tracking shift register is cleared, so in-flight memory data is discarded.

Decomposition:
- Package defs holds the existing NEIGHBOURS_CNT plus these additions:
  - NBR_CNT_W=4
  - typedef enum nbr_cnt_state_t {IDLE, ISSUE, DRAIN, RESULT}
  - default rule constants B3_MASK and S23_MASK
- One sub-module: nbr_addr_gen. It is combinational, parametrised by FIELD_W/FIELD_H/WRAP, and produces 8 x/y addresses plus relevance flags. With WRAP=1 all relevance flags are 1.
- The engine walks a 4-bit issue index over the sub-module outputs.

Test Plan:
1. WRAP=0, RD_LAT=1, memory all 1, request (0,0) -> exactly 4 reads: (1,0), (0,1), (1,1), then self (0,0). o_res_valid 6 cycles after accept; cnt=3, cur=1, next=1.
2. WRAP=0, live (0,1), (1,1), (2,1), request (1,0) -> 6 reads; cnt=3, cur=0, next=1. Request (1,1) -> cnt=2, cur=1, next=1.
3. WRAP=1, only (3,2) live, request (0,0) -> 9 reads, first read address (3,2); cnt=1, cur=0, next=0.
4. Hold i_res_ready=0 for 10 cycles after o_res_valid -> all result outputs stable, o_req_ready=0, o_rd_en=0 throughout. Release -> o_req_ready=1 next cycle.
5. Assert i_rst_n=0 for one cycle after the 3rd read, with RD_LAT=3 -> next cycle o_rd_en=0, o_res_valid=0, o_req_ready=1. A new request to an interior cell returns a count unaffected by stale responses.
6. RD_LAT in {1,3}, WRAP in {0,1}, random field, sweep all 12 cells -> o_nbr_cnt and o_next_state match a scoreboard model using the B3/S23 rule.
